// File: rtl/imem_pkg.sv
// Shared types and constants for the loadable instruction memory.
// Defines the FSM state encoding, word width and the default NOP word.
package imem_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] NOP_WORD_DEFAULT = 32'hE1A00000;  // MOV R0,R0

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

endpackage

// File: rtl/imem_loadable_if.sv
// Fetch port and byte-wide loader port of the loadable instruction memory.
// Master is the core/loader side; slave is the memory.
interface imem_loadable_if #(
    parameter int DEPTH = 64
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [imem_pkg::WORD_W-1:0] a;
    logic [imem_pkg::WORD_W-1:0] rd;
    logic                        fault;
    logic                        busy;
    logic                        ld_start;
    logic                        ld_valid;
    logic [7:0]                  ld_byte;
    logic                        ld_last;
    logic                        ld_ready;
    logic [CW-1:0]               ld_words;
    logic                        ld_ovf;

    modport master (
        output a, ld_start, ld_valid, ld_byte, ld_last,
        input  rd, fault, busy, ld_ready, ld_words, ld_ovf
    );

    modport slave (
        input  a, ld_start, ld_valid, ld_byte, ld_last,
        output rd, fault, busy, ld_ready, ld_words, ld_ovf
    );

endinterface

// File: rtl/imem_byte_packer.sv
// Assembles accepted loader bytes little-endian into 32-bit words.
// A word is emitted on the lane-3 byte, or zero-padded early on ld_last.
module imem_byte_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              accept,
    input  logic [7:0]        byte_in,
    input  logic              last,
    output logic              word_valid,
    output logic [WORD_W-1:0] word_data,
    output logic              word_last
);

    logic [1:0]        lane;
    logic [WORD_W-1:0] partial;

    // Lanes at and above the current one are always zero in partial, so a
    // short final word comes out zero-padded without extra masking.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        word_data                     = partial;
        word_data[{lane, 3'b000} +: 8] = byte_in;
        word_valid                    = accept && ((lane == 2'd3) || last);
        word_last                     = accept && last;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane    <= '0;
            partial <= '0;
        end else if (clr || word_valid) begin
            lane    <= '0;
            partial <= '0;
        end else if (accept) begin
            partial[{lane, 3'b000} +: 8] <= byte_in;
            lane                         <= lane + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loadable.sv
// Run-time loadable ARM instruction memory: load FSM, write pointer, RAM
// and a bounds-checked fetch port with optional registered read.
module imem_loadable
    import imem_pkg::*;
#(
    parameter int                DEPTH    = 64,
    parameter int                REG_READ = 0,
    parameter logic [WORD_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input logic            clk,
    input logic            reset,
    imem_loadable_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    state_t            state, state_nxt;
    logic [AW-1:0]     ptr;
    logic [CW-1:0]     words;
    logic              ovf;
    logic              ld_ready;
    logic              accept;
    logic              word_valid;
    logic              word_last;
    logic [WORD_W-1:0] word_data;
    logic              at_end;
    logic [WORD_W-1:0] ram [DEPTH];

    assign ld_ready = (state == LOAD) && !bus.ld_start;
    assign accept   = bus.ld_valid && ld_ready;
    assign at_end   = word_valid && (ptr == AW'(DEPTH - 1));

    imem_byte_packer u_packer (
        .clk        (clk),
        .rst        (reset),
        .clr        (bus.ld_start),
        .accept     (accept),
        .byte_in    (bus.ld_byte),
        .last       (bus.ld_last),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_last  (word_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RUN: if (bus.ld_start) state_nxt = LOAD;
            LOAD: begin
                if (bus.ld_start)              state_nxt = LOAD;
                else if (word_last || at_end)  state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ld_start from any state restarts the image: pointer, count and overflow clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr   <= '0;
            words <= '0;
            ovf   <= 1'b0;
        end else if (bus.ld_start) begin
            ptr   <= '0;
            words <= '0;
            ovf   <= 1'b0;
        end else if (word_valid) begin
            ptr   <= ptr + AW'(1);
            words <= (words == CW'(DEPTH)) ? words : words + CW'(1);
            if (at_end && !word_last) ovf <= 1'b1;
        end
    end

    // NOTE: the RAM has no reset; stale contents are hidden by words == 0.
    always_ff @(posedge clk) begin
        if (word_valid) ram[ptr] <= word_data;
    end

    logic [29:0]       index;
    logic              fault_c;
    logic              hit;
    logic [WORD_W-1:0] rd_c;

    // Bounds checks use the full 30-bit index so high addresses never alias.
    always_comb begin
        index   = bus.a[31:2];
        fault_c = (bus.a[1:0] != 2'b00) || ({2'b00, index} >= 32'(DEPTH));
        hit     = !fault_c && (state != LOAD) && ({2'b00, index} < 32'(words));
        rd_c    = hit ? ram[index[AW-1:0]] : NOP_WORD;
    end

    generate
        if (REG_READ != 0) begin : g_reg_read
            logic [WORD_W-1:0] rd_q;
            logic              fault_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    rd_q    <= NOP_WORD;
                    fault_q <= 1'b0;
                end else begin
                    rd_q    <= rd_c;
                    fault_q <= fault_c;
                end
            end
            assign bus.rd    = rd_q;
            assign bus.fault = fault_q;
        end else begin : g_comb_read
            assign bus.rd    = rd_c;
            assign bus.fault = fault_c;
        end
    endgenerate

    assign bus.busy     = (state == LOAD);
    assign bus.ld_ready = ld_ready;
    assign bus.ld_words = words;
    assign bus.ld_ovf   = ovf;

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: three instances (64/comb, 16/comb, 64/registered)
// share one stimulus stream; fetch results are checked via vector tables.
module tb_imem_loadable;
    import imem_pkg::*;

    localparam logic [31:0] NOP = 32'hE1A00000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] rd;
        logic        fault;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t tbl[];

    always #5 clk = ~clk;

    imem_loadable_if #(.DEPTH(64)) b0 ();
    imem_loadable_if #(.DEPTH(16)) b1 ();
    imem_loadable_if #(.DEPTH(64)) b2 ();

    imem_loadable #(.DEPTH(64), .REG_READ(0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    imem_loadable #(.DEPTH(16), .REG_READ(0)) u1 (.clk(clk), .reset(reset), .bus(b1));
    imem_loadable #(.DEPTH(64), .REG_READ(1)) u2 (.clk(clk), .reset(reset), .bus(b2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic [31:0] v);
        b0.a = v;
        b1.a = v;
        b2.a = v;
    endtask

    task automatic drive_ld(input logic s, input logic v, input logic [7:0] d, input logic l);
        b0.ld_start = s; b0.ld_valid = v; b0.ld_byte = d; b0.ld_last = l;
        b1.ld_start = s; b1.ld_valid = v; b1.ld_byte = d; b1.ld_last = l;
        b2.ld_start = s; b2.ld_valid = v; b2.ld_byte = d; b2.ld_last = l;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        drive_ld(1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        drive_ld(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic stream(input logic [7:0] d[$], input logic last_on_end);
        for (int i = 0; i < d.size(); i++) begin
            @(negedge clk);
            drive_ld(1'b0, 1'b1, d[i], last_on_end && (i == d.size() - 1));
        end
        @(negedge clk);
        drive_ld(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // Comb instances compare in the same cycle; the registered one via the
    // scoreboard one cycle later, and must still hold the previous result before that.
    task automatic run_table(input string tag);
        vec_t        exp;
        logic [31:0] prev_rd;
        prev_rd = NOP;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive_a(tbl[i].a);
            sb.push_back(tbl[i]);
            #1;
            check($sformatf("%s[%0d] u0.rd", tag, i), b0.rd, tbl[i].rd);
            check($sformatf("%s[%0d] u0.fault", tag, i), 32'(b0.fault), 32'(tbl[i].fault));
            check($sformatf("%s[%0d] u1.rd", tag, i), b1.rd, tbl[i].rd);
            if (i > 0) check($sformatf("%s[%0d] u2.rd stale", tag, i), b2.rd, prev_rd);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                check($sformatf("%s[%0d] scoreboard empty", tag, i), 32'd0, 32'd1);
            end else begin
                exp = sb.pop_front();
                check($sformatf("%s[%0d] u2.rd", tag, i), b2.rd, exp.rd);
                check($sformatf("%s[%0d] u2.fault", tag, i), 32'(b2.fault), 32'(exp.fault));
                prev_rd = exp.rd;
            end
        end
    endtask

    initial begin
        logic [7:0] img[$];

        reset = 1'b1;
        drive_a(32'h0);
        drive_ld(1'b0, 1'b0, 8'h00, 1'b0);
        #12;
        check("reset u0.rd", b0.rd, NOP);
        check("reset u0.fault", 32'(b0.fault), 32'd0);
        check("reset u0.busy", 32'(b0.busy), 32'd0);
        check("reset u0.ld_words", 32'(b0.ld_words), 32'd0);
        check("reset u0.ld_ready", 32'(b0.ld_ready), 32'd0);
        check("reset u2.rd", b2.rd, NOP);
        check("reset u2.fault", 32'(b2.fault), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Two full words, ld_last on the final byte.
        pulse_start();
        #1;
        check("load1 busy", 32'(b0.busy), 32'd1);
        check("load1 ld_ready", 32'(b0.ld_ready), 32'd1);
        img = '{8'h02, 8'h10, 8'hA0, 8'hE3, 8'h03, 8'h20, 8'hA0, 8'hE3};
        stream(img, 1'b1);
        #1;
        check("load1 u0.ld_words", 32'(b0.ld_words), 32'd2);
        check("load1 u2.ld_words", 32'(b2.ld_words), 32'd2);
        check("load1 u0.busy", 32'(b0.busy), 32'd0);
        tbl = new[5];
        tbl[0] = '{32'h0000_0000, 32'hE3A01002, 1'b0};
        tbl[1] = '{32'h0000_0004, 32'hE3A02003, 1'b0};
        tbl[2] = '{32'h0000_0008, NOP,          1'b0};
        tbl[3] = '{32'h0000_0002, NOP,          1'b1};
        tbl[4] = '{32'h0000_0100, NOP,          1'b1};
        run_table("load1");

        // Five bytes: last word is a lone lane-0 byte, zero-padded.
        pulse_start();
        img = '{8'hAA, 8'h00, 8'hA0, 8'hE3, 8'h55};
        stream(img, 1'b1);
        #1;
        check("load2 ld_words", 32'(b0.ld_words), 32'd2);
        check("load2 busy", 32'(b0.busy), 32'd0);
        tbl = new[4];
        tbl[0] = '{32'h0000_0000, 32'hE3A000AA, 1'b0};
        tbl[1] = '{32'h0000_0004, 32'h0000_0055, 1'b0};
        tbl[2] = '{32'h0000_0001, NOP,           1'b1};
        tbl[3] = '{32'h0000_0100, NOP,           1'b1};
        run_table("load2");

        // Restart mid-word: byte offered with ld_start is refused, partial word dropped.
        pulse_start();
        img = '{8'hDE, 8'hAD, 8'hBE};
        stream(img, 1'b0);
        @(negedge clk);
        drive_ld(1'b1, 1'b1, 8'hFF, 1'b0);
        #1;
        check("restart u0.ld_ready", 32'(b0.ld_ready), 32'd0);
        check("restart u2.ld_ready", 32'(b2.ld_ready), 32'd0);
        @(negedge clk);
        drive_ld(1'b0, 1'b0, 8'h00, 1'b0);
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        stream(img, 1'b1);
        #1;
        check("restart ld_words", 32'(b0.ld_words), 32'd1);
        tbl = new[2];
        tbl[0] = '{32'h0000_0000, 32'h4433_2211, 1'b0};
        tbl[1] = '{32'h0000_0004, NOP,           1'b0};
        run_table("restart");

        // Overflow: 68 bytes without ld_last; only the 16-word instance fills up.
        pulse_start();
        for (int i = 0; i < 68; i++) begin
            @(negedge clk);
            drive_ld(1'b0, 1'b1, 8'(i), 1'b0);
            #1;
            if (i == 63) begin
                check("ovf pre u1.ld_ready", 32'(b1.ld_ready), 32'd1);
                check("ovf pre u1.ld_ovf", 32'(b1.ld_ovf), 32'd0);
            end
            if (i == 64) begin
                check("ovf u1.ld_ready", 32'(b1.ld_ready), 32'd0);
                check("ovf u1.ld_ovf", 32'(b1.ld_ovf), 32'd1);
                check("ovf u1.ld_words", 32'(b1.ld_words), 32'd16);
                check("ovf u1.busy", 32'(b1.busy), 32'd0);
                check("ovf u0.ld_ready", 32'(b0.ld_ready), 32'd1);
                check("ovf u0.ld_ovf", 32'(b0.ld_ovf), 32'd0);
            end
        end
        @(negedge clk);
        drive_ld(1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("ovf u0.ld_words", 32'(b0.ld_words), 32'd17);
        check("ovf u1.ld_words end", 32'(b1.ld_words), 32'd16);
        check("ovf u1.ld_ovf sticky", 32'(b1.ld_ovf), 32'd1);
        drive_a(32'h0000_003C);
        #1;
        check("ovf u1.rd last word", b1.rd, 32'h3F3E_3D3C);
        check("ovf u0.rd busy", b0.rd, NOP);
        drive_a(32'h0000_0040);
        #1;
        check("ovf u1.fault depth", 32'(b1.fault), 32'd1);
        check("ovf u0.fault depth", 32'(b0.fault), 32'd0);
        pulse_start();
        #1;
        check("ovf clear u1.ld_ovf", 32'(b1.ld_ovf), 32'd0);
        check("ovf clear u1.ld_words", 32'(b1.ld_words), 32'd0);
        check("ovf clear u1.busy", 32'(b1.busy), 32'd1);

        // Asynchronous reset in the middle of a load.
        drive_a(32'h0);
        img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        stream(img, 1'b0);
        #1;
        check("midload u2.ld_words", 32'(b2.ld_words), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("midreset u2.busy", 32'(b2.busy), 32'd0);
        check("midreset u2.ld_words", 32'(b2.ld_words), 32'd0);
        check("midreset u2.rd", b2.rd, NOP);
        check("midreset u0.ld_words", 32'(b0.ld_words), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("postreset u2.rd", b2.rd, NOP);
        check("postreset u2.ld_ready", 32'(b2.ld_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised successor to the fixed ARM instruction ROM: same word-aligned instruction read port, but contents are streamed in at run time through a byte-wide loader port instead of being hard-coded.
- Tracks how many words are valid; returns a NOP for unloaded, out-of-range or misaligned fetches and flags faults.
- Sits between the program-load path (testbench/UART loader) and the single-cycle/multicycle ARM core fetch stage.

Parameters:
- DEPTH, 64, number of 32-bit words (power of two, 16..4096)
- REG_READ, 0, 0 = combinational read (legacy timing), 1 = registered read with 1-cycle latency
- NOP_WORD, 32'hE1A00000, word returned for invalid fetches (MOV R0,R0)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- a  in  32  fetch byte address
- rd  out  32  instruction word
- fault  out  1  fetch was misaligned (a[1:0]!=0) or a[31:2] >= DEPTH
- busy  out  1  load in progress; core must stall
- ld_start  in  1  begin new load (pulse)
- ld_valid  in  1  ld_byte valid
- ld_byte  in  8  load data byte
- ld_last  in  1  qualifies final byte of image
- ld_ready  out  1  loader accepts byte this cycle
- ld_words  out  $clog2(DEPTH)+1  count of valid loaded words
- ld_ovf  out  1  sticky: image exceeded DEPTH

Behaviour:
- Clock and reset: one clock, clk; reset asynchronous, active-high. Reset: state=IDLE, ld_words=0, ld_ovf=0, busy=0, ld_ready=0, byte lane=0, write pointer=0. If REG_READ=1, rd=NOP_WORD and fault=0. RAM contents are not reset; they are invalidated via ld_words=0.
- FSM states IDLE, LOAD, RUN:
  - IDLE -ld_start-> LOAD.
  - RUN -ld_start-> LOAD.
  - LOAD -(accepted byte with ld_last) or overflow-> RUN.
  - ld_start while in LOAD restarts the load: partial word discarded, pointer=0, lane=0, ld_words=0, ld_ovf cleared.
  - Entering LOAD always clears ld_words and ld_ovf.
- Load path:
  - ld_ready=1 only in LOAD, and never in the cycle ld_start is sampled.
  - Byte accepted when ld_valid&ld_ready. Bytes assemble little-endian: lane 0 -> bits[7:0] ... lane 3 -> bits[31:24].
  - On lane-3 accept, the word is written at the pointer on that clock edge; pointer++ and ld_words++ in the same cycle.
  - ld_last on a lane 0-2 byte: word is zero-padded in the upper lanes, written, ld_words++, then -> RUN.
  - ld_last without ld_valid is ignored.
  - Full word written at pointer=DEPTH-1 with further bytes pending (no ld_last): ld_ovf=1 -> RUN. Excess bytes are not accepted (ld_ready=0).
- Read path:
  - index=a[31:2].
  - fault=(a[1:0]!=0) | (index>=DEPTH).
  - rd=NOP_WORD if fault, busy, or index>=ld_words; otherwise RAM[index].
  - REG_READ=0: rd/fault are combinational in a. REG_READ=1: rd/fault register a's result, appearing the cycle after a is presented.
  - Read of a word written in the same cycle returns the old word/NOP; the new value is visible the next cycle.
- busy=1 exactly while in LOAD.
- Widths: ld_words saturates at DEPTH. Index compare uses full a[31:2], never truncated to $clog2(DEPTH) bits, so aliasing is impossible.

Decomposition:
- Package imem_pkg: state enum (IDLE/LOAD/RUN), NOP_WORD default, WORD_W=32.
- One natural sub-module, imem_byte_packer: lane counter plus word assembly, emits word_valid/word_data/word_last.
- Top block holds the FSM, pointer, RAM and read path.

Test Plan:
- Reset, REG_READ=0, a=0 -> rd=E1A00000, fault=0, busy=0, ld_words=0.
- ld_start, stream 8 bytes 02 10 A0 E3 03 20 A0 E3 (last on 8th) -> ld_words=2, a=0 -> rd=E3A01002, a=4 -> E3A02003, a=8 -> E1A00000.
- Stream 5 bytes AA 00 A0 E3 55 with ld_last -> ld_words=2, word1=00000055, state RUN, busy=0.
- a=0x00000002 -> fault=1, rd=NOP. a=4*DEPTH (0x100 for DEPTH=64) -> fault=1, rd=NOP, no aliasing to word 0.
- DEPTH=16, stream 68 bytes, no ld_last -> ld_ovf=1, ld_words=16, ld_ready=0 after byte 64. A following ld_start clears ld_ovf.
- REG_READ=1: a changes 0 -> 4 -> rd follows one cycle late. Assert reset mid-load (after 6 bytes) -> busy=0, ld_words=0, rd=NOP next cycle.
